// File: rtl/ram_1rw1r_bytemask.sv
// 1RW+1R synchronous RAM with per-byte write mask, optional write-first forwarding
// on the read-only port, and a zero-fill sweep sequencer run after reset or on clr.
module ram_1rw1r_bytemask #(
    parameter int AW           = 10,
    parameter int DW           = 64,
    parameter int BW           = 8,
    parameter int CLEAR_ON_RST = 1,
    parameter int BYPASS       = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             ready,
    input  logic [AW-1:0]    addr0,
    input  logic             re0,
    input  logic             we0,
    input  logic [DW/BW-1:0] wm0,
    input  logic [DW-1:0]    wr0,
    output logic [DW-1:0]    rd0,
    output logic             rv0,
    input  logic [AW-1:0]    addr1,
    input  logic             re1,
    output logic [DW-1:0]    rd1,
    output logic             rv1
);

    localparam int NB    = DW / BW;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    if ((DW % BW) != 0) begin : g_bad_width
        $error("ram_1rw1r_bytemask: DW must be a multiple of BW");
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    // Replace the masked granules of old_data with the matching granules of new_data.
    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_data,
                                                  input logic [DW-1:0] new_data,
                                                  input logic [NB-1:0] mask);
        logic [DW-1:0] res;
        res = old_data;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                res[i*BW +: BW] = new_data[i*BW +: BW];
            end else begin
                res[i*BW +: BW] = old_data[i*BW +: BW];
            end
        end
        return res;
    endfunction

    logic [DW-1:0] mem_r [0:DEPTH-1];
    state_t        state_r;
    logic [AW-1:0] ptr_r;
    logic          ready_r;
    logic [DW-1:0] rd0_r;
    logic [DW-1:0] rd1_r;
    logic          rv0_r;
    logic          rv1_r;

    logic [DW-1:0] old0_s;
    logic [DW-1:0] old1_s;
    logic [DW-1:0] rd1_next_s;

    assign old0_s = mem_r[addr0];
    assign old1_s = mem_r[addr1];

    // Port-1 read data: forward the in-flight port-0 write when it hits the same entry.
    always_comb begin
        rd1_next_s = old1_s;
        if ((BYPASS != 0) && we0 && (addr1 == addr0)) begin
            rd1_next_s = merge_bytes(old1_s, wr0, wm0);
        end else begin
            rd1_next_s = old1_s;
        end
    end

    // Storage update: sweep zeroes one entry per cycle, otherwise masked port-0 writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_r == ST_CLEAR) begin
                mem_r[ptr_r] <= '0;
            end else if (we0) begin
                for (int i = 0; i < NB; i++) begin
                    if (wm0[i]) begin
                        mem_r[addr0][i*BW +: BW] <= wr0[i*BW +: BW];
                    end
                end
            end
        end
    end

    // Sequencer and registered read ports; requests are only honoured in READY.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= RST_STATE;
            ptr_r   <= '0;
            ready_r <= 1'b0;
            rd0_r   <= '0;
            rd1_r   <= '0;
            rv0_r   <= 1'b0;
            rv1_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    rv0_r <= 1'b0;
                    rv1_r <= 1'b0;
                    ptr_r <= ptr_r + PTR_ONE;
                    if (ptr_r == PTR_LAST) begin
                        state_r <= ST_READY;
                        ready_r <= 1'b1;
                    end
                end
                ST_READY: begin
                    rv0_r   <= re0;
                    rv1_r   <= re1;
                    ready_r <= 1'b1;
                    if (re0) begin
                        rd0_r <= old0_s;
                    end
                    if (re1) begin
                        rd1_r <= rd1_next_s;
                    end
                    if (clr) begin
                        state_r <= ST_CLEAR;
                        ptr_r   <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= RST_STATE;
                    ptr_r   <= '0;
                    ready_r <= 1'b0;
                    rv0_r   <= 1'b0;
                    rv1_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign rd0   = rd0_r;
    assign rv0   = rv0_r;
    assign rd1   = rd1_r;
    assign rv1   = rv1_r;

endmodule

// File: tb/tb_ram_1rw1r_bytemask.sv
// Directed bench: two instances (forwarding on / off) driven in lockstep with a
// vector table, plus hand-written clear-sweep and mid-sweep reset sequences.
module tb_ram_1rw1r_bytemask;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [9:0]  addr0;
    logic        re0;
    logic        we0;
    logic [7:0]  wm0;
    logic [63:0] wr0;
    logic [9:0]  addr1;
    logic        re1;

    logic        ready,    ready_nb;
    logic [63:0] rd0,      rd0_nb;
    logic        rv0,      rv0_nb;
    logic [63:0] rd1,      rd1_nb;
    logic        rv1,      rv1_nb;

    int errors = 0;
    int checks = 0;

    ram_1rw1r_bytemask dut (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready),
        .addr0(addr0), .re0(re0), .we0(we0), .wm0(wm0), .wr0(wr0),
        .rd0(rd0), .rv0(rv0),
        .addr1(addr1), .re1(re1), .rd1(rd1), .rv1(rv1)
    );

    ram_1rw1r_bytemask #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready_nb),
        .addr0(addr0), .re0(re0), .we0(we0), .wm0(wm0), .wr0(wr0),
        .rd0(rd0_nb), .rv0(rv0_nb),
        .addr1(addr1), .re1(re1), .rd1(rd1_nb), .rv1(rv1_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  a0;
        logic        r0;
        logic        w0;
        logic [7:0]  m0;
        logic [63:0] d0;
        logic [9:0]  a1;
        logic        r1;
        logic [63:0] e_rd0;
        logic        e_rv0;
        logic [63:0] e_rd1;
        logic        e_rv1;
        logic [63:0] e_rd1_nb;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [9:0] a0, input logic r0, input logic w0,
                                input logic [7:0] m0, input logic [63:0] d0,
                                input logic [9:0] a1, input logic r1,
                                input logic [63:0] e_rd0, input logic e_rv0,
                                input logic [63:0] e_rd1, input logic e_rv1,
                                input logic [63:0] e_rd1_nb);
        vec_t v;
        v.a0 = a0; v.r0 = r0; v.w0 = w0; v.m0 = m0; v.d0 = d0;
        v.a1 = a1; v.r1 = r1;
        v.e_rd0 = e_rd0; v.e_rv0 = e_rv0;
        v.e_rd1 = e_rd1; v.e_rv1 = e_rv1; v.e_rd1_nb = e_rd1_nb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; re0 = 1'b0; we0 = 1'b0; re1 = 1'b0;
        wm0 = 8'h00; wr0 = 64'h0; addr0 = 10'd0; addr1 = 10'd0;
    endtask

    // Count edges until ready rises, starting from an already-elapsed count.
    task automatic wait_ready(input string nm, input int start);
        int n;
        n = start;
        while (ready !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk(nm, 64'(n), 64'd1024);
        chk({nm, " nb"}, {63'd0, ready_nb}, 64'd1);
    endtask

    initial begin
        vecs[0]  = mk(10'd3,    1'b1, 1'b0, 8'h00, 64'h0, 10'd9, 1'b1,
                      64'h0, 1'b1, 64'h0, 1'b1, 64'h0);
        vecs[1]  = mk(10'd5,    1'b0, 1'b1, 8'hFF, 64'h1122334455667788, 10'd0, 1'b0,
                      64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
        vecs[2]  = mk(10'd5,    1'b1, 1'b0, 8'h00, 64'h0, 10'd5, 1'b1,
                      64'h1122334455667788, 1'b1, 64'h1122334455667788, 1'b1, 64'h1122334455667788);
        vecs[3]  = mk(10'd5,    1'b1, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 10'd5, 1'b1,
                      64'h1122334455667788, 1'b1, 64'h11223344AAAAAAAA, 1'b1, 64'h1122334455667788);
        vecs[4]  = mk(10'd5,    1'b1, 1'b0, 8'h00, 64'h0, 10'd0, 1'b0,
                      64'h11223344AAAAAAAA, 1'b1, 64'h11223344AAAAAAAA, 1'b0, 64'h1122334455667788);
        vecs[5]  = mk(10'd7,    1'b1, 1'b1, 8'hFF, 64'hDEADBEEFDEADBEEF, 10'd7, 1'b1,
                      64'h0, 1'b1, 64'hDEADBEEFDEADBEEF, 1'b1, 64'h0);
        vecs[6]  = mk(10'd7,    1'b1, 1'b0, 8'h00, 64'h0, 10'd7, 1'b1,
                      64'hDEADBEEFDEADBEEF, 1'b1, 64'hDEADBEEFDEADBEEF, 1'b1, 64'hDEADBEEFDEADBEEF);
        vecs[7]  = mk(10'd9,    1'b0, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 10'd9, 1'b1,
                      64'hDEADBEEFDEADBEEF, 1'b0, 64'h0, 1'b1, 64'h0);
        vecs[8]  = mk(10'd9,    1'b1, 1'b0, 8'h00, 64'h0, 10'd1023, 1'b1,
                      64'h0, 1'b1, 64'h0, 1'b1, 64'h0);
        vecs[9]  = mk(10'd1023, 1'b0, 1'b1, 8'h81, 64'h0102030405060708, 10'd1023, 1'b1,
                      64'h0, 1'b0, 64'h0100000000000008, 1'b1, 64'h0);
        vecs[10] = mk(10'd1023, 1'b1, 1'b0, 8'h00, 64'h0, 10'd5, 1'b1,
                      64'h0100000000000008, 1'b1, 64'h11223344AAAAAAAA, 1'b1, 64'h11223344AAAAAAAA);

        // Reset state.
        idle();
        rst = 1'b0;
        step();
        step();
        chk("rst rd0", rd0, 64'h0);
        chk("rst rd1", rd1, 64'h0);
        chk("rst rv", {62'd0, rv0, rv1}, 64'h0);
        chk("rst ready", {63'd0, ready}, 64'h0);

        // Power-on sweep.
        rst = 1'b1;
        wait_ready("init sweep len", 0);

        // Table-driven functional vectors.
        for (int i = 0; i < 11; i++) begin
            addr0 = vecs[i].a0; re0 = vecs[i].r0; we0 = vecs[i].w0;
            wm0 = vecs[i].m0; wr0 = vecs[i].d0;
            addr1 = vecs[i].a1; re1 = vecs[i].r1;
            step();
            chk($sformatf("v%0d rd0", i), rd0, vecs[i].e_rd0);
            chk($sformatf("v%0d rv0", i), {63'd0, rv0}, {63'd0, vecs[i].e_rv0});
            chk($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d rv1", i), {63'd0, rv1}, {63'd0, vecs[i].e_rv1});
            chk($sformatf("v%0d rd1 nb", i), rd1_nb, vecs[i].e_rd1_nb);
            chk($sformatf("v%0d rd0 nb", i), rd0_nb, vecs[i].e_rd0);
        end
        idle();

        // clr sweep with requests presented mid-sweep.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr ready drop", {63'd0, ready}, 64'h0);
        repeat (100) step();
        addr0 = 10'd5; we0 = 1'b1; re0 = 1'b1; wm0 = 8'hFF; wr0 = 64'hFFFFFFFFFFFFFFFF;
        addr1 = 10'd5; re1 = 1'b1;
        step();
        chk("clear rv0", {63'd0, rv0}, 64'h0);
        chk("clear rv1", {63'd0, rv1}, 64'h0);
        idle();
        wait_ready("clr sweep len", 101);
        addr0 = 10'd5; re0 = 1'b1; addr1 = 10'd7; re1 = 1'b1;
        step();
        chk("post clr rd0", rd0, 64'h0);
        chk("post clr rv0", {63'd0, rv0}, 64'h1);
        chk("post clr rd1", rd1, 64'h0);
        addr0 = 10'd1023; addr1 = 10'd9;
        step();
        chk("post clr rd0 1023", rd0, 64'h0);
        chk("post clr rd1 9", rd1, 64'h0);
        idle();

        // Reset in the middle of a sweep restarts it.
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (499) step();
        chk("mid ready", {63'd0, ready}, 64'h0);
        rst = 1'b0;
        step();
        chk("mid rst ready", {63'd0, ready}, 64'h0);
        chk("mid rst rv", {62'd0, rv0, rv1}, 64'h0);
        rst = 1'b1;
        wait_ready("restart sweep len", 0);
        addr0 = 10'd5; re0 = 1'b1;
        step();
        chk("restart rd0", rd0, 64'h0);
        chk("restart rv0", {63'd0, rv0}, 64'h1);
        idle();
        step();
        chk("rv0 strobe", {63'd0, rv0}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
